and2xn_skid_stage: RTL and testbench

//  Registered, flow-controlled bitwise-AND stage: O = I0 & I1 over WIDTH lanes.

---
 rtl/and2xn_skid_stage.sv | 123 ++++++++++++
 tb/tb_and2xn_skid_stage.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/and2xn_skid_stage.sv
// Registered bitwise-AND stage with a valid/ready handshake, 2-entry skid buffer and a hit counter.
// Define AND2XN_HIT_SAT_EN to make hit_cnt saturate and to drive hit_sat.
module and2xn_skid_stage #(
    parameter int unsigned WIDTH = 2,
    parameter int unsigned CNT_W = 8
) (
    input  logic             CLK,
    input  logic             ASYNCRESET,
    input  logic [WIDTH-1:0] I0,
    input  logic [WIDTH-1:0] I1,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] O,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] hit_cnt,
    output logic             hit_sat
);

    logic [WIDTH-1:0] main_q, main_d;
    logic             main_valid_q, main_valid_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             skid_valid_q, skid_valid_d;
    logic             in_ready_q, in_ready_d;
    logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
    logic             accept_c;
    logic             deliver_c;
    logic [WIDTH-1:0] and_c;

    assign and_c     = I0 & I1;
    assign accept_c  = in_valid & in_ready_q;
    assign deliver_c = main_valid_q & out_ready;

    // Storage and counter registers; in_ready is held low throughout reset.
    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            main_q       <= '0;
            main_valid_q <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b0;
            hit_cnt_q    <= '0;
        end else begin
            main_q       <= main_d;
            main_valid_q <= main_valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
            hit_cnt_q    <= hit_cnt_d;
        end
    end

    // Next-state: skid refill on deliver, new data into main when it frees up.
    always_comb begin
        main_d       = main_q;
        main_valid_d = main_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;

        if (deliver_c) begin
            if (skid_valid_q) begin
                main_d       = skid_q;
                skid_valid_d = 1'b0;
            end else begin
                main_valid_d = 1'b0;
            end
        end

        // accept_c implies skid empty, so the skid branch above never collides
        if (accept_c) begin
            if (!main_valid_q || deliver_c) begin
                main_d       = and_c;
                main_valid_d = 1'b1;
            end else begin
                skid_d       = and_c;
                skid_valid_d = 1'b1;
            end
        end

        in_ready_d = !skid_valid_d;
    end

`ifdef AND2XN_HIT_SAT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic hit_sat_q, hit_sat_d;

    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            hit_sat_q <= 1'b0;
        end else begin
            hit_sat_q <= hit_sat_d;
        end
    end

    // Saturating hit counter with sticky saturation flag.
    always_comb begin
        hit_cnt_d = hit_cnt_q;
        if (deliver_c && (main_q != '0) && (hit_cnt_q != CNT_MAX)) begin
            hit_cnt_d = hit_cnt_q + CNT_W'(1);
        end
        hit_sat_d = hit_sat_q | (hit_cnt_d == CNT_MAX);
    end

    assign hit_sat = hit_sat_q;
`else
    // Wrapping hit counter.
    always_comb begin
        hit_cnt_d = hit_cnt_q;
        if (deliver_c && (main_q != '0)) begin
            hit_cnt_d = hit_cnt_q + CNT_W'(1);
        end
    end

    assign hit_sat = 1'b0;
`endif

    assign in_ready  = in_ready_q;
    assign O         = main_q;
    assign out_valid = main_valid_q;
    assign hit_cnt   = hit_cnt_q;

endmodule

// File: tb/tb_and2xn_skid_stage.sv
// Scoreboard bench for and2xn_skid_stage (WIDTH=2, CNT_W=2); expectations follow AND2XN_HIT_SAT_EN.
module tb_and2xn_skid_stage;

    localparam int unsigned WIDTH = 2;
    localparam int unsigned CNT_W = 2;

    logic             CLK = 1'b0;
    logic             ASYNCRESET = 1'b0;
    logic [WIDTH-1:0] I0 = '0;
    logic [WIDTH-1:0] I1 = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] O;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [CNT_W-1:0] hit_cnt;
    logic             hit_sat;

    int checks   = 0;
    int failures = 0;
    int n_deliv  = 0;
    logic [WIDTH-1:0] sb[$];

    and2xn_skid_stage #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .ASYNCRESET(ASYNCRESET), .I0(I0), .I1(I1),
        .in_valid(in_valid), .in_ready(in_ready), .O(O), .out_valid(out_valid),
        .out_ready(out_ready), .hit_cnt(hit_cnt), .hit_sat(hit_sat)
    );

    always #5 CLK = ~CLK;

    // Scoreboard: pop/compare on delivery, push on accept, both sampled mid-cycle.
    always @(negedge CLK) begin
        if (!ASYNCRESET) begin
            if (out_valid && out_ready) begin
                checks++;
                n_deliv++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL sb_unexpected: got O=%b with nothing expected", O);
                end else begin
                    logic [WIDTH-1:0] e;
                    e = sb.pop_front();
                    if (O !== e) begin
                        failures++;
                        $display("FAIL sb_order: O=%b expected %b", O, e);
                    end
                end
            end
            if (in_valid && in_ready) sb.push_back(I0 & I1);
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        step();
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        ASYNCRESET = 1'b1;
        repeat (3) step();
        ASYNCRESET = 1'b0;
        sb.delete();
        n_deliv = 0;
        step();
    endtask

    function automatic logic [CNT_W-1:0] exp_cnt(input int n);
`ifdef AND2XN_HIT_SAT_EN
        return (n >= 3) ? CNT_W'(3) : CNT_W'(n);
`else
        return CNT_W'(n % 4);
`endif
    endfunction

    task automatic test_reset();
        step();
        ASYNCRESET = 1'b1;
        repeat (3) begin
            @(negedge CLK);
            checks++;
            if (in_ready !== 1'b0) begin
                failures++;
                $display("FAIL reset_in_ready: got %b expected 0", in_ready);
            end
        end
        step();
        ASYNCRESET = 1'b0;
        sb.delete();
        step();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || O !== 2'b00 || hit_cnt !== '0 || hit_sat !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: rdy=%b ov=%b O=%b cnt=%0d sat=%b expected 1 0 00 0 0",
                     in_ready, out_valid, O, hit_cnt, hit_sat);
        end
    endtask

    task automatic test_single();
        do_reset();
        I0 = 2'b11; I1 = 2'b10; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        @(negedge CLK);
        checks++;
        if (out_valid !== 1'b1 || O !== 2'b10) begin
            failures++;
            $display("FAIL single_out: ov=%b O=%b expected 1 10", out_valid, O);
        end
        step();
        @(negedge CLK);
        checks++;
        if (hit_cnt !== CNT_W'(1) || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_hit: cnt=%0d ov=%b expected 1 0", hit_cnt, out_valid);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; I0 = 2'b01; I1 = 2'b01;
        step();
        I0 = 2'b11; I1 = 2'b10;
        @(negedge CLK);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_ready1: got %b expected 1", in_ready);
        end
        step();
        I0 = 2'b11; I1 = 2'b11;
        repeat (2) begin
            @(negedge CLK);
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || O !== 2'b01) begin
                failures++;
                $display("FAIL bp_full: rdy=%b ov=%b O=%b expected 0 1 01", in_ready, out_valid, O);
            end
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge CLK);
        checks++;
        if (out_valid !== 1'b1 || O !== 2'b01) begin
            failures++;
            $display("FAIL bp_first: ov=%b O=%b expected 1 01", out_valid, O);
        end
        step();
        @(negedge CLK);
        checks++;
        if (out_valid !== 1'b1 || O !== 2'b10) begin
            failures++;
            $display("FAIL bp_second: ov=%b O=%b expected 1 10", out_valid, O);
        end
        step();
        @(negedge CLK);
        checks++;
        if (out_valid !== 1'b0 || O !== 2'b10 || sb.size() != 0 || hit_cnt !== exp_cnt(2)) begin
            failures++;
            $display("FAIL bp_drain: ov=%b O=%b left=%0d cnt=%0d expected 0 10 0 %0d",
                     out_valid, O, sb.size(), hit_cnt, exp_cnt(2));
        end
    endtask

    task automatic test_back_to_back();
        int nz = 0;
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            logic [WIDTH-1:0] a, b;
            a = WIDTH'($urandom);
            b = WIDTH'($urandom);
            I0 = a; I1 = b; in_valid = 1'b1;
            if ((a & b) != '0) nz++;
            @(negedge CLK);
            checks++;
            if (in_ready !== 1'b1 || (i > 0 && out_valid !== 1'b1)) begin
                failures++;
                $display("FAIL stream_rate: cycle %0d rdy=%b ov=%b expected 1 1", i, in_ready, out_valid);
            end
            step();
        end
        in_valid = 1'b0;
        repeat (2) step();
        @(negedge CLK);
        checks++;
        if (n_deliv != 16 || sb.size() != 0 || hit_cnt !== exp_cnt(nz)) begin
            failures++;
            $display("FAIL stream_total: deliv=%0d left=%0d cnt=%0d expected 16 0 %0d",
                     n_deliv, sb.size(), hit_cnt, exp_cnt(nz));
        end
    endtask

    task automatic test_counter_end();
        do_reset();
        out_ready = 1'b1;
        in_valid = 1'b1; I0 = 2'b01; I1 = 2'b11;
        repeat (5) step();
        in_valid = 1'b0;
        repeat (2) step();
        @(negedge CLK);
        checks++;
`ifdef AND2XN_HIT_SAT_EN
        if (hit_cnt !== 2'd3 || hit_sat !== 1'b1) begin
            failures++;
            $display("FAIL cnt_end: cnt=%0d sat=%b expected 3 1", hit_cnt, hit_sat);
        end
`else
        if (hit_cnt !== 2'd1 || hit_sat !== 1'b0) begin
            failures++;
            $display("FAIL cnt_end: cnt=%0d sat=%b expected 1 0", hit_cnt, hit_sat);
        end
`endif
    endtask

    task automatic test_reset_mid();
        do_reset();
        out_ready = 1'b1;
        in_valid = 1'b1; I0 = 2'b10; I1 = 2'b10;
        step();
        in_valid = 1'b0;
        step();
        out_ready = 1'b0; in_valid = 1'b1; I0 = 2'b01; I1 = 2'b01;
        repeat (2) step();
        in_valid = 1'b0;
        @(negedge CLK);
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || hit_cnt !== CNT_W'(1)) begin
            failures++;
            $display("FAIL mid_full: ov=%b rdy=%b cnt=%0d expected 1 0 1", out_valid, in_ready, hit_cnt);
        end
        #2;
        ASYNCRESET = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || hit_cnt !== '0 || in_ready !== 1'b0 || O !== 2'b00) begin
            failures++;
            $display("FAIL mid_async: ov=%b cnt=%0d rdy=%b O=%b expected 0 0 0 00",
                     out_valid, hit_cnt, in_ready, O);
        end
        sb.delete();
        repeat (2) step();
        ASYNCRESET = 1'b0;
        out_ready = 1'b1;
        step();
        @(negedge CLK);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || n_deliv != 1) begin
            failures++;
            $display("FAIL mid_after: ov=%b rdy=%b deliv=%0d expected 0 1 1", out_valid, in_ready, n_deliv);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_counter_end();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
